// File: rtl/sia_pkt_pkg.sv
// Shared constants and state encodings for the SIA packet parser.
// Rx packets: RX_HDR, cmd, len, len payload bytes.
// Tx responses: TX_HDR, cmd, len, len payload bytes.
package sia_pkt_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned WORK_W   = 640;
  localparam int unsigned TARGET_W = 32;
  localparam int unsigned IMG_W    = WORK_W + TARGET_W;

  localparam logic [7:0] RX_HDR    = 8'hAA;
  localparam logic [7:0] TX_HDR    = 8'h55;
  localparam logic [7:0] CMD_WORK  = 8'h00;
  localparam logic [7:0] CMD_LOOP  = 8'h01;
  localparam logic [7:0] WORK_LEN  = 8'd84;
  localparam logic [7:0] NONCE_LEN = 8'd4;

  typedef enum logic [1:0] {RX_IDLE, RX_CMD, RX_LEN, RX_DATA} rx_state_t;

  // TX_HEAD is the state that emits the TX_HDR byte.
  typedef enum logic [2:0] {TX_IDLE, TX_HEAD, TX_CMD, TX_LEN, TX_DATA} tx_state_t;

endpackage

// File: rtl/sia_pkt_tx.sv
// Response serializer: sends nonce and loop-echo responses to the UART tx.
// Ports: clk, rst (sync, active-high); tx_busy in; tx_data/new_tx_data out;
//   loop_req/loop_len in, loop_rd_idx out, loop_rd_data in, loop_done_c out;
//   nonce/nonce_valid in, nonce_ready out.
module sia_pkt_tx import sia_pkt_pkg::*; #(
  parameter int unsigned IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_busy,
  output logic [BYTE_W-1:0] tx_data,
  output logic              new_tx_data,
  input  logic              loop_req,
  input  logic [7:0]        loop_len,
  output logic [IDX_W-1:0]  loop_rd_idx,
  input  logic [7:0]        loop_rd_data,
  output logic              loop_done_c,
  input  logic [31:0]       nonce,
  input  logic              nonce_valid,
  output logic              nonce_ready
);

  tx_state_t   state_q, state_n;
  logic        sel_nonce_q, sel_nonce_n;
  logic [7:0]  idx_q, idx_n;
  logic [7:0]  len_q, len_n;
  logic [31:0] nonce_q, nonce_n;
  logic        pend_q, pend_n;
  logic [7:0]  tx_data_n;
  logic        strobe_n;
  logic        ready_n;
  logic        send_ok;

  assign loop_rd_idx = idx_q[IDX_W-1:0];

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= TX_IDLE;
      sel_nonce_q <= 1'b0;
      idx_q       <= 8'd0;
      len_q       <= 8'd0;
      nonce_q     <= 32'd0;
      pend_q      <= 1'b0;
      tx_data     <= 8'd0;
      new_tx_data <= 1'b0;
      nonce_ready <= 1'b0;
    end else begin
      state_q     <= state_n;
      sel_nonce_q <= sel_nonce_n;
      idx_q       <= idx_n;
      len_q       <= len_n;
      nonce_q     <= nonce_n;
      pend_q      <= pend_n;
      tx_data     <= tx_data_n;
      new_tx_data <= strobe_n;
      nonce_ready <= ready_n;
    end
  end

  // Next-state and byte selection; one strobe per byte, never back to back.
  always_comb begin
    state_n     = state_q;
    sel_nonce_n = sel_nonce_q;
    idx_n       = idx_q;
    len_n       = len_q;
    nonce_n     = nonce_q;
    pend_n      = pend_q;
    tx_data_n   = tx_data;
    strobe_n    = 1'b0;
    loop_done_c = 1'b0;
    send_ok     = !tx_busy && !new_tx_data;

    if (nonce_valid && nonce_ready) begin
      nonce_n = nonce;
      pend_n  = 1'b1;
    end

    case (state_q)
      TX_IDLE: begin
        // Nonce response has priority over a queued loop echo.
        if (pend_q) begin
          sel_nonce_n = 1'b1;
          len_n       = NONCE_LEN;
          idx_n       = 8'd0;
          state_n     = TX_HEAD;
        end else if (loop_req) begin
          sel_nonce_n = 1'b0;
          len_n       = loop_len;
          idx_n       = 8'd0;
          state_n     = TX_HEAD;
        end
      end
      TX_HEAD: if (send_ok) begin
        strobe_n  = 1'b1;
        tx_data_n = TX_HDR;
        state_n   = TX_CMD;
      end
      TX_CMD: if (send_ok) begin
        strobe_n  = 1'b1;
        // Nonce responses reuse command code 0x00.
        tx_data_n = sel_nonce_q ? CMD_WORK : CMD_LOOP;
        state_n   = TX_LEN;
      end
      TX_LEN: if (send_ok) begin
        strobe_n  = 1'b1;
        tx_data_n = len_q;
        state_n   = TX_DATA;
      end
      TX_DATA: if (send_ok) begin
        strobe_n  = 1'b1;
        tx_data_n = sel_nonce_q ? nonce_q[{idx_q[1:0], 3'b000} +: 8] : loop_rd_data;
        idx_n     = idx_q + 8'd1;
        if (idx_q == len_q - 8'd1) begin
          state_n = TX_IDLE;
          if (sel_nonce_q) pend_n = 1'b0;
          else             loop_done_c = 1'b1;
        end
      end
      default: state_n = TX_IDLE;
    endcase

    ready_n = (state_n == TX_IDLE) && !pend_n;
  end

endmodule

// File: rtl/sia_pkt_parser.sv
// SIA packet parser: decodes rx packets into work/target updates and loop
// echoes, and hands responses to the sia_pkt_tx serializer.
// Ports: clk, rst (sync, active-high); rx_data/new_rx_data in;
//   tx_data/new_tx_data out, tx_busy in; work/target/work_valid out;
//   nonce/nonce_valid in, nonce_ready out.
// Optional: define SIA_PARSER_TIMEOUT_EN to abandon rx packets after
//   TIMEOUT_CYCLES idle cycles.
module sia_pkt_parser import sia_pkt_pkg::*; #(
  parameter int unsigned LOOP_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   rx_data,
  input  logic                new_rx_data,
  output logic [BYTE_W-1:0]   tx_data,
  output logic                new_tx_data,
  input  logic                tx_busy,
  output logic [WORK_W-1:0]   work,
  output logic [TARGET_W-1:0] target,
  output logic                work_valid,
  input  logic [31:0]         nonce,
  input  logic                nonce_valid,
  output logic                nonce_ready
);

  localparam int unsigned LOOP_IW = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

  rx_state_t               rx_state, rx_state_n;
  logic [7:0]              cmd_q, len_q, cnt_q;
  logic                    keep_work, keep_loop;
  logic                    last_c;
  logic                    timeout_c;
  logic [IMG_W-BYTE_W-1:0] img;
  logic [IMG_W-1:0]        img_n;
  logic [7:0]              loop_mem [LOOP_DEPTH];
  logic                    loop_pend;
  logic [7:0]              loop_len;
  logic [LOOP_IW-1:0]      loop_rd_idx;
  logic                    loop_done_c;

  // Byte k of the payload ends up at bits [8k+7:8k] after the final shift.
  assign img_n = {rx_data, img};

`ifdef SIA_PARSER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Idle-cycle counter, only running while a packet is in progress.
  always_ff @(posedge clk) begin
    if (rst || new_rx_data || rx_state == RX_IDLE) to_cnt <= '0;
    else                                           to_cnt <= to_cnt + TO_W'(1);
  end

  assign timeout_c = (rx_state != RX_IDLE) && !new_rx_data &&
                     (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_c      = 1'b0;
`endif

  // Rx state register.
  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_state_n;
  end

  // Rx next-state logic.
  always_comb begin
    rx_state_n = rx_state;
    last_c     = 1'b0;
    case (rx_state)
      RX_IDLE: if (new_rx_data && rx_data == RX_HDR) rx_state_n = RX_CMD;
      RX_CMD:  if (new_rx_data) rx_state_n = RX_LEN;
      RX_LEN:  if (new_rx_data) rx_state_n = (rx_data == 8'd0) ? RX_IDLE : RX_DATA;
      RX_DATA: if (new_rx_data && cnt_q == len_q - 8'd1) begin
        rx_state_n = RX_IDLE;
        last_c     = 1'b1;
      end
      default: rx_state_n = RX_IDLE;
    endcase
    if (timeout_c) rx_state_n = RX_IDLE;
  end

  // Packet fields, accept decisions, work outputs and loop occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q      <= 8'd0;
      len_q      <= 8'd0;
      cnt_q      <= 8'd0;
      keep_work  <= 1'b0;
      keep_loop  <= 1'b0;
      loop_pend  <= 1'b0;
      loop_len   <= 8'd0;
      work       <= '0;
      target     <= '0;
      work_valid <= 1'b0;
    end else begin
      work_valid <= 1'b0;
      if (loop_done_c) loop_pend <= 1'b0;
      if (new_rx_data) begin
        case (rx_state)
          RX_CMD: cmd_q <= rx_data;
          RX_LEN: begin
            len_q     <= rx_data;
            cnt_q     <= 8'd0;
            keep_work <= (cmd_q == CMD_WORK) && (rx_data == WORK_LEN);
            // A loop echo is refused while the previous one is still owed.
            keep_loop <= (cmd_q == CMD_LOOP) && (rx_data != 8'd0) &&
                         (32'(rx_data) <= LOOP_DEPTH) && !loop_pend;
          end
          RX_DATA: begin
            cnt_q <= cnt_q + 8'd1;
            if (last_c && keep_work) begin
              work       <= img_n[WORK_W-1:0];
              target     <= img_n[IMG_W-1:WORK_W];
              work_valid <= 1'b1;
            end
            if (last_c && keep_loop) begin
              loop_pend <= 1'b1;
              loop_len  <= len_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Work shift image and loop payload storage (no reset needed).
  always_ff @(posedge clk) begin
    if (new_rx_data && rx_state == RX_DATA) begin
      if (keep_work) img <= img_n[IMG_W-1:BYTE_W];
      if (keep_loop) loop_mem[cnt_q[LOOP_IW-1:0]] <= rx_data;
    end
  end

  sia_pkt_tx #(.IDX_W(LOOP_IW)) u_tx (
    .clk          (clk),
    .rst          (rst),
    .tx_busy      (tx_busy),
    .tx_data      (tx_data),
    .new_tx_data  (new_tx_data),
    .loop_req     (loop_pend),
    .loop_len     (loop_len),
    .loop_rd_idx  (loop_rd_idx),
    .loop_rd_data (loop_mem[loop_rd_idx]),
    .loop_done_c  (loop_done_c),
    .nonce        (nonce),
    .nonce_valid  (nonce_valid),
    .nonce_ready  (nonce_ready)
  );

endmodule
